// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
package pc_gen_pkg;

  typedef enum logic [2:0] {
    SRC_HOLD,
    SRC_SEQ,
    SRC_CALL,
    SRC_RET,
    SRC_EX,
    SRC_TRAP
  } pc_src_e;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// the top entry is read combinationally so a return can redirect in the same cycle.
module ras_stack
  import pc_gen_pkg::*;
#(
  parameter int W         = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  logic [W-1:0] push_data_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [W-1:0]  r_mem [RAS_DEPTH];
  logic [PW-1:0] r_top;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_top_inc;
  logic [PW-1:0] w_top_dec;
  logic          w_push_en;

  // Pointer arithmetic wraps naturally because the depth is a power of two.
  assign w_top_inc = r_top + PW'(1);
  assign w_top_dec = r_top - PW'(1);
  assign w_push_en = push_i & ~clear_i & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (push_i) begin
      r_top <= w_top_inc;
      if (r_count != CW'(RAS_DEPTH)) r_count <= r_count + CW'(1);
    end else if (pop_i) begin
      r_top   <= w_top_dec;
      r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push_en) r_mem[w_top_inc] <= push_data_i;
  end

  assign top_o   = r_mem[r_top];
  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == CW'(RAS_DEPTH));

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: prioritised redirects (trap, EX, RAS return,
// ID call) over a handshake-gated sequential advance.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int          W         = 32,
  parameter logic [W-1:0] RESET_PC = '0,
  parameter int          RAS_DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         stall_i,
  input  logic         imem_ready_i,
  input  logic         trap_i,
  input  logic [W-1:0] trap_pc_i,
  input  logic         ex_redirect_i,
  input  logic [W-1:0] ex_target_i,
  input  logic         id_call_i,
  input  logic         id_ret_i,
  input  logic [W-1:0] id_target_i,
  input  logic [W-1:0] id_link_i,
  output logic [W-1:0] pc_o,
  output logic         pc_valid_o,
  output logic         redirect_o,
  output logic         ras_empty_o,
  output logic         ras_full_o
);

  logic [W-1:0] r_pc;
  logic         r_valid;
  logic [W-1:0] w_ras_top;
  logic         w_acc;
  logic         w_id_ok;
  logic         w_ret_ok;
  pc_src_e      w_src;
  logic [W-1:0] w_pc_next;

  assign w_acc    = r_valid & imem_ready_i & ~stall_i;
  assign w_id_ok  = ~stall_i & ~trap_i & ~ex_redirect_i;
  assign w_ret_ok = id_ret_i & w_id_ok & ~ras_empty_o;

  always_comb begin
    w_src = SRC_HOLD;
    if (trap_i)                    w_src = SRC_TRAP;
    else if (ex_redirect_i)        w_src = SRC_EX;
    else if (w_ret_ok)             w_src = SRC_RET;
    else if (id_call_i & w_id_ok)  w_src = SRC_CALL;
    else if (w_acc)                w_src = SRC_SEQ;
  end

  // Redirect targets are word-aligned by dropping the two low bits.
  always_comb begin
    w_pc_next = r_pc;
    case (w_src)
      SRC_TRAP: w_pc_next = {trap_pc_i[W-1:2],   2'b00};
      SRC_EX:   w_pc_next = {ex_target_i[W-1:2], 2'b00};
      SRC_RET:  w_pc_next = {w_ras_top[W-1:2],   2'b00};
      SRC_CALL: w_pc_next = {id_target_i[W-1:2], 2'b00};
      SRC_SEQ:  w_pc_next = r_pc + W'(PC_STEP);
      default:  w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_valid <= 1'b1;
    end
  end

  ras_stack #(
    .W         (W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_src == SRC_CALL),
    .pop_i       (w_src == SRC_RET),
    .clear_i     (trap_i),
    .push_data_i (id_link_i),
    .top_o       (w_ras_top),
    .empty_o     (ras_empty_o),
    .full_o      (ras_full_o)
  );

  assign pc_o       = r_pc;
  assign pc_valid_o = r_valid;
  assign redirect_o = ~rst_i & ((w_src == SRC_TRAP) | (w_src == SRC_EX) |
                                (w_src == SRC_RET)  | (w_src == SRC_CALL));

endmodule
